// File: rtl/cfr_cpg_alloc.sv
// cfr_cpg_alloc: schedules detected CFR peaks onto a bank of cancellation
// pulse generators (CPGs), round-robin, tracking how long each CPG stays busy
// and keeping saturating allocation/drop statistics.
// Optional feature: define CFR_CPG_ALLOC_MIN_SPACING_EN to drop any peak that
// arrives less than MIN_SPACING clk cycles after the previously accepted one.
module cfr_cpg_alloc #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CPG        = 6,
    parameter int CPW_LEN_CYCLES = 128,
    parameter int STAT_WIDTH     = 16,
    parameter int MIN_SPACING    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         peak_valid_in,
    input  logic signed [DATA_WIDTH-1:0] peak_i_in,
    input  logic signed [DATA_WIDTH-1:0] peak_q_in,
    input  logic                         peak_phase_in,
    input  logic                         ctrl_enable,
    input  logic                         stat_clear,
    output logic [NUM_CPG-1:0]           cpg_start,
    output logic signed [DATA_WIDTH-1:0] cpg_peak_i,
    output logic signed [DATA_WIDTH-1:0] cpg_peak_q,
    output logic                         cpg_phase,
    output logic [NUM_CPG-1:0]           cpg_busy,
    output logic [STAT_WIDTH-1:0]        stat_alloc_cnt,
    output logic [STAT_WIDTH-1:0]        stat_drop_cnt
);

    localparam int CW = $clog2(CPW_LEN_CYCLES + 1);
    localparam int PW = $clog2(NUM_CPG);
    localparam logic [CW-1:0] PULSE_LEN = CW'(CPW_LEN_CYCLES);
    localparam logic [PW-1:0] LAST_CPG  = PW'(NUM_CPG - 1);

    logic [CW-1:0]      cnt      [NUM_CPG];
    logic [CW-1:0]      cnt_next [NUM_CPG];
    logic [NUM_CPG-1:0] eligible;
    logic [NUM_CPG-1:0] start_vec;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      pick;
    logic               found;
    logic               spacing_ok;
    logic               request;
    logic               alloc;
    logic               drop;
    int                 search_idx;

`ifdef CFR_CPG_ALLOC_MIN_SPACING_EN
    localparam int SPW = $clog2(MIN_SPACING) + 1;
    logic [SPW-1:0] spacing_cnt;

    assign spacing_ok = (spacing_cnt == '0);

    // Spacing window: reload after every accepted peak, then count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spacing_cnt <= '0;
        end else if (alloc) begin
            spacing_cnt <= SPW'(MIN_SPACING - 1);
        end else if (spacing_cnt != '0) begin
            spacing_cnt <= spacing_cnt - 1'b1;
        end
    end
`else
    assign spacing_ok = 1'b1;
`endif

    assign request = peak_valid_in && ctrl_enable;
    assign alloc   = request && spacing_ok && found;
    assign drop    = request && !alloc;

    // A CPG may be reused in the very cycle its pulse ends (count of 1)
    always_comb begin
        for (int k = 0; k < NUM_CPG; k++) begin
            eligible[k] = (cnt[k] <= CW'(1));
        end
    end

    // Round-robin search: first eligible CPG at or after rr_ptr, wrapping
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        search_idx = 0;
        for (int i = 0; i < NUM_CPG; i++) begin
            search_idx = int'(rr_ptr) + i;
            if (search_idx >= NUM_CPG) begin
                search_idx = search_idx - NUM_CPG;
            end
            if (!found && eligible[search_idx]) begin
                found = 1'b1;
                pick  = PW'(search_idx);
            end
        end
    end

    // Next busy-counter values: load on allocation, otherwise run down to zero
    always_comb begin
        for (int k = 0; k < NUM_CPG; k++) begin
            if (alloc && (pick == PW'(k))) begin
                cnt_next[k] = PULSE_LEN;
            end else if (cnt[k] != '0) begin
                cnt_next[k] = cnt[k] - 1'b1;
            end else begin
                cnt_next[k] = '0;
            end
        end
    end

    // One-hot start strobe for the chosen CPG
    always_comb begin
        start_vec       = '0;
        start_vec[pick] = alloc;
    end

    // Busy counters and the registered busy flags derived from them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CPG; k++) begin
                cnt[k] <= '0;
            end
            cpg_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_CPG; k++) begin
                cnt[k]      <= cnt_next[k];
                cpg_busy[k] <= (cnt_next[k] != '0);
            end
        end
    end

    // Start strobe, broadcast peak data and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpg_start  <= '0;
            cpg_peak_i <= '0;
            cpg_peak_q <= '0;
            cpg_phase  <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            cpg_start <= start_vec;
            if (alloc) begin
                cpg_peak_i <= peak_i_in;
                cpg_peak_q <= peak_q_in;
                cpg_phase  <= peak_phase_in;
                rr_ptr     <= (pick == LAST_CPG) ? '0 : pick + 1'b1;
            end
        end
    end

    // Saturating statistics; a clear wins over an event in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alloc_cnt <= '0;
            stat_drop_cnt  <= '0;
        end else if (stat_clear) begin
            stat_alloc_cnt <= '0;
            stat_drop_cnt  <= '0;
        end else begin
            if (alloc && (stat_alloc_cnt != '1)) begin
                stat_alloc_cnt <= stat_alloc_cnt + 1'b1;
            end
            if (drop && (stat_drop_cnt != '1)) begin
                stat_drop_cnt <= stat_drop_cnt + 1'b1;
            end
        end
    end

endmodule
